// File: rtl/ext_interleave_buffer.sv
// Ping-pong extrinsic buffer: natural-order capture, QPP-interleaved replay with valid/ready.
// Define EXT_SCALE_EN to scale incoming LLRs by 0.75 before they are stored.
module ext_interleave_buffer #(
  parameter int CODELENGTH = 256,
  parameter int BITLENGTH  = 16,
  parameter int F1         = 15,
  parameter int F2         = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BITLENGTH-1:0] ext_in,
  input  logic                 ext_valid,
  output logic                 in_ready,
  output logic [BITLENGTH-1:0] ap_out,
  output logic                 ap_valid,
  input  logic                 ap_ready,
  output logic                 ap_last,
  output logic                 overflow
);

  localparam int AW = $clog2(CODELENGTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(CODELENGTH - 1);
  localparam logic [AW-1:0] G_INIT   = AW'((F1 + F2) % CODELENGTH);
  localparam logic [AW-1:0] G_STEP   = AW'((2 * F2) % CODELENGTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM
  } rd_state_e;

  logic [BITLENGTH-1:0] bank_mem [2][CODELENGTH];
  logic [BITLENGTH-1:0] wr_data;
  logic [BITLENGTH-1:0] rd_data_q;

  logic          wr_sel_q, wr_sel_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]    full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          wr_en, wr_done;

  rd_state_e     state_q, state_d;
  logic          rd_sel_q, rd_sel_d;
  logic [AW-1:0] f_q, f_d;
  logic [AW-1:0] g_q, g_d;
  logic [AW-1:0] j_q, j_d;
  logic          rd_release;

`ifdef EXT_SCALE_EN
  // x - (x >>> 2) never exceeds |x|, so no saturation is required.
  assign wr_data = $signed(ext_in) - ($signed(ext_in) >>> 2);
`else
  assign wr_data = ext_in;
`endif

  assign in_ready = !full_q[wr_sel_q];
  assign wr_en    = ext_valid && in_ready;
  assign wr_done  = wr_en && (wr_cnt_q == LAST_IDX);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_sel_d   = wr_sel_q;
    wr_cnt_d   = wr_cnt_q;
    overflow_d = overflow_q || (ext_valid && !in_ready);
    if (wr_en) begin
      if (wr_done) begin
        wr_cnt_d = '0;
        wr_sel_d = !wr_sel_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  // f tracks the QPP address of output j; g is its first difference, stepped by 2*F2.
  always_comb begin
    state_d    = state_q;
    rd_sel_d   = rd_sel_q;
    f_d        = f_q;
    g_d        = g_q;
    j_d        = j_q;
    rd_release = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_sel_q]) begin
          state_d = S_PRIME;
          f_d     = '0;
          g_d     = G_INIT;
          j_d     = '0;
        end
      end
      S_PRIME: state_d = S_STREAM;
      S_STREAM: begin
        if (ap_ready) begin
          if (j_q == LAST_IDX) begin
            rd_release = 1'b1;
            rd_sel_d   = !rd_sel_q;
            f_d        = '0;
            g_d        = G_INIT;
            j_d        = '0;
            state_d    = full_q[!rd_sel_q] ? S_PRIME : S_IDLE;
          end else begin
            f_d = f_q + g_q;
            g_d = g_q + G_STEP;
            j_d = j_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The two banks are distinct, so completion and release in one cycle never collide.
  always_comb begin
    full_d = full_q;
    if (wr_done)    full_d[wr_sel_q] = 1'b1;
    if (rd_release) full_d[rd_sel_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_sel_q   <= 1'b0;
      wr_cnt_q   <= '0;
      full_q     <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      rd_sel_q   <= 1'b0;
      f_q        <= '0;
      g_q        <= G_INIT;
      j_q        <= '0;
    end else begin
      wr_sel_q   <= wr_sel_d;
      wr_cnt_q   <= wr_cnt_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      rd_sel_q   <= rd_sel_d;
      f_q        <= f_d;
      g_q        <= g_d;
      j_q        <= j_d;
    end
  end

  // NOTE: the RAM array has no reset; full_q gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (wr_en) bank_mem[wr_sel_q][wr_cnt_q] <= wr_data;
  end

  // Reading the next-state address keeps the output at one sample per cycle and stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= bank_mem[rd_sel_d][f_d];
  end

  assign ap_out   = rd_data_q;
  assign ap_valid = (state_q == S_STREAM);
  assign ap_last  = ap_valid && (j_q == LAST_IDX);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ext_interleave_buffer.sv
// Scoreboard bench for ext_interleave_buffer: a frame model predicts the interleaved
// stream; a negedge monitor pops and compares every accepted output.
module tb_ext_interleave_buffer;

  localparam int K        = 256;
  localparam int BW       = 16;
  localparam int F1       = 15;
  localparam int F2       = 32;
  localparam int WAIT_MAX = 4000;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] ext_in;
  logic          ext_valid;
  logic          in_ready;
  logic [BW-1:0] ap_out;
  logic          ap_valid;
  logic          ap_ready;
  logic          ap_last;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rdy_mode = 2;

  exp_t          sb[$];
  logic [BW-1:0] wbuf[$];

  logic lat_req    = 1'b0;
  logic lat_armed  = 1'b0;
  logic run_armed  = 1'b0;
  int   exp_rise   = 0;
  int   run_len    = 0;

  ext_interleave_buffer #(
    .CODELENGTH(K),
    .BITLENGTH (BW),
    .F1        (F1),
    .F2        (F2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ext_in   (ext_in),
    .ext_valid(ext_valid),
    .in_ready (in_ready),
    .ap_out   (ap_out),
    .ap_valid (ap_valid),
    .ap_ready (ap_ready),
    .ap_last  (ap_last),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int qpp(input int j);
    return (F1 * j + F2 * j * j) % K;
  endfunction

  function automatic logic [BW-1:0] model_scale(input logic [BW-1:0] x);
`ifdef EXT_SCALE_EN
    int v;
    v = int'($signed(x));
    return BW'(v - int'($floor(real'(v) / 4.0)));
`else
    return x;
`endif
  endfunction

  // Stored frame is complete: queue its samples in interleaved order.
  task automatic model_accept(input logic [BW-1:0] d);
    exp_t e;
    wbuf.push_back(model_scale(d));
    if (wbuf.size() == K) begin
      for (int j = 0; j < K; j++) begin
        e.data = wbuf[qpp(j)];
        e.last = (j == K - 1);
        sb.push_back(e);
      end
      wbuf.delete();
      if (lat_req) begin
        lat_req   = 1'b0;
        lat_armed = 1'b1;
        exp_rise  = cyc + 3;
      end
    end
  endtask

  // Wait (bounded) for in_ready, then present one sample for a single edge.
  task automatic push_sample(input logic [BW-1:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < WAIT_MAX) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(waited), 32'(0));
      return;
    end
    ext_in    = d;
    ext_valid = 1'b1;
    model_accept(d);
    @(posedge clk);
    #1;
    ext_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || ap_valid) && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(sb.size()), 32'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    ext_valid = 1'b0;
    wbuf.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       ap_ready = 1'b1;
      1:       ap_ready = 1'($urandom_range(0, 1));
      default: ap_ready = 1'b0;
    endcase
  end

  // Monitor: stall stability, scoreboard compare, latency and burst length.
  initial begin
    logic          prev_stall = 1'b0;
    logic          prev_valid = 1'b0;
    logic [BW-1:0] prev_out   = '0;
    logic          prev_last  = 1'b0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(ap_valid), 32'(1));
          check("stall_data", 32'(ap_out), 32'(prev_out));
          check("stall_last", 32'(ap_last), 32'(prev_last));
        end
        if (ap_valid && !prev_valid && lat_armed) begin
          check("latency_rise_cycle", 32'(cyc), 32'(exp_rise));
          lat_armed = 1'b0;
          run_armed = 1'b1;
          run_len   = 0;
        end
        if (run_armed) begin
          if (ap_valid) run_len++;
          else begin
            check("burst_length", 32'(run_len), 32'(K));
            run_armed = 1'b0;
          end
        end
        if (ap_valid && ap_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 32'(ap_out), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("ap_out", 32'(ap_out), 32'(e.data));
            check("ap_last", 32'(ap_last), 32'(e.last));
          end
        end
        prev_stall = ap_valid && !ap_ready;
        prev_valid = ap_valid;
        prev_out   = ap_out;
        prev_last  = ap_last;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    ext_in    = '0;
    ext_valid = 1'b0;
    ap_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ap_out", 32'(ap_out), 32'(0));
    check("reset_ap_valid", 32'(ap_valid), 32'(0));
    check("reset_ap_last", 32'(ap_last), 32'(0));
    check("reset_overflow", 32'(overflow), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'(1));

    // Order and latency: natural ramp, downstream always ready.
    rdy_mode = 0;
    lat_req  = 1'b1;
    for (int i = 0; i < K; i++) push_sample(BW'(i));
    wait_drain();
    check("order_overflow", 32'(overflow), 32'(0));
    check("latency_observed", 32'({lat_armed, run_armed, lat_req}), 32'(0));

    // Backpressure: same ramp, then random data including scaling corner values.
    rdy_mode = 1;
    for (int i = 0; i < K; i++) push_sample(BW'(i));
    wait_drain();
    push_sample(16'h0100);
    push_sample(16'hFFFC);
    push_sample(16'h8000);
    for (int i = 3; i < K; i++) push_sample(BW'($urandom));
    wait_drain();

    // Ping-pong: two frames buffered while stalled, one dropped sample, then a third frame.
    rdy_mode = 2;
    for (int i = 0; i < 2 * K; i++) push_sample(BW'($urandom));
    @(negedge clk);
    check("pingpong_in_ready", 32'(in_ready), 32'(0));
    check("pingpong_overflow_before", 32'(overflow), 32'(0));
    ext_in    = 16'h1234;
    ext_valid = 1'b1;
    @(posedge clk);
    #1;
    ext_valid = 1'b0;
    @(negedge clk);
    check("pingpong_overflow_set", 32'(overflow), 32'(1));
    check("pingpong_stalled_valid", 32'(ap_valid), 32'(1));
    rdy_mode = 1;
    for (int i = 0; i < K; i++) push_sample(BW'($urandom));
    wait_drain();
    check("pingpong_overflow_sticky", 32'(overflow), 32'(1));

    // Reset mid-frame: partial frame discarded, fresh frame streams in order.
    rdy_mode = 0;
    for (int i = 0; i < 100; i++) push_sample(BW'($urandom));
    do_reset();
    @(negedge clk);
    check("midreset_overflow", 32'(overflow), 32'(0));
    check("midreset_ap_valid", 32'(ap_valid), 32'(0));
    check("midreset_in_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < K; i++) push_sample(BW'(i));
    wait_drain();
    repeat (5) @(negedge clk);
    check("final_idle_valid", 32'(ap_valid), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
